// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
package clk_div_pkg;

   localparam int unsigned DIV_MIN = 2;

   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned div_clamp(input int unsigned value);
      return (value < DIV_MIN) ? DIV_MIN : value;
   endfunction

   function automatic int unsigned half_up(input int unsigned div);
      return (div + 1) / 2;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write channel: valid/ready request plus a one-cycle error strobe.
interface clk_div_bank_if
   import clk_div_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 8
);
   localparam int CH_W = ch_bits(CHANNELS);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: run flag, phase counter, active and pending divisor.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_div_i,
   output logic             pend_o,
   output logic             tick_o,
   output logic             sq_o,
   output logic             sq_n_o
);
   logic             run_q, run_d;
   logic             pv_q, pv_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] pd_q, pd_d;
   logic             wrap, apply;

   assign wrap  = run_q & (cnt_q == div_q - DIV_W'(1));
   // sync and a stopped channel both count as a period boundary
   assign apply = pv_q & (sync_i | wrap | ~run_q);

   always_comb begin
      run_d = en_i;
      cnt_d = cnt_q + DIV_W'(1);
      div_d = div_q;
      pv_d  = pv_q;
      pd_d  = pd_q;
      if (~en_i | ~run_q | sync_i | wrap) begin
         cnt_d = '0;
      end
      if (apply) begin
         div_d = pd_q;
         pv_d  = 1'b0;
      end
      if (wr_i) begin
         pv_d = 1'b1;
         pd_d = DIV_W'(div_clamp(32'(wr_div_i)));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q <= 1'b0;
         pv_q  <= 1'b0;
         cnt_q <= '0;
         div_q <= DIV_W'(DEFAULT_DIV);
         pd_q  <= DIV_W'(DEFAULT_DIV);
      end else begin
         run_q <= run_d;
         pv_q  <= pv_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
         pd_q  <= pd_d;
      end
   end

   assign pend_o = pv_q;
   assign tick_o = wrap;
   assign sq_o   = run_q & (32'(cnt_q) < half_up(32'(div_q)));
   assign sq_n_o = run_q & ~sq_o;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock-enable dividers sharing one config port.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] ch_en,
   clk_div_bank_if.slave       cfg,
   input  logic                sync_req,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] sq,
   output logic [CHANNELS-1:0] sq_n
);
   localparam int CH_W  = ch_bits(CHANNELS);
   localparam int SLOTS = 2 ** CH_W;
   localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

   logic [CHANNELS-1:0] pend_v;
   logic [SLOTS-1:0]    busy;
   logic                in_range, xfer;
   logic                err_q, err_d;

   // unused address slots read as idle so stray writes are accepted
   always_comb begin
      busy                 = '0;
      busy[CHANNELS-1:0]   = pend_v;
   end

   assign in_range      = {1'b0, cfg.cfg_ch} < CH_LIM;
   assign cfg.cfg_ready = ~busy[cfg.cfg_ch];
   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
   assign err_d         = xfer & ~in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign cfg.cfg_err = err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clk_div_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i    (clk),
         .rst_i    (rst),
         .en_i     (ch_en[i]),
         .sync_i   (sync_req),
         .wr_i     (xfer & in_range & (cfg.cfg_ch == CH_W'(i))),
         .wr_div_i (cfg.cfg_div),
         .pend_o   (pend_v[i]),
         .tick_o   (tick[i]),
         .sq_o     (sq[i]),
         .sq_n_o   (sq_n[i])
      );
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a timestamp-based period model.
module tb_clk_div_bank;
   localparam int NCH = 3;
   localparam int DW  = 8;
   localparam int DEF = 2;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] ch_en;
   logic           sync_req;
   logic [NCH-1:0] tick, sq, sq_n;

   clk_div_bank_if #(.CHANNELS(NCH), .DIV_W(DW)) bus ();

   clk_div_bank #(
      .CHANNELS    (NCH),
      .DIV_W       (DW),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_en    (ch_en),
      .cfg      (bus),
      .sync_req (sync_req),
      .tick     (tick),
      .sq       (sq),
      .sq_n     (sq_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: each channel remembers the cycle its current period began.
   int       cyc = 0;
   bit       m_ok = 0;
   bit [NCH-1:0] m_run, m_pv;
   int       m_n[NCH];
   int       m_pd[NCH];
   int       m_start[NCH];
   bit       m_err;

   function automatic bit m_ready();
      if (int'(bus.cfg_ch) >= NCH) return 1'b1;
      return !m_pv[bus.cfg_ch];
   endfunction

   always @(posedge clk) begin : model
      int pos;
      bit ending, xfer, inr;
      inr  = int'(bus.cfg_ch) < NCH;
      xfer = bus.cfg_valid && m_ready();
      for (int i = 0; i < NCH; i++) begin
         pos    = cyc - m_start[i];
         ending = m_run[i] && (pos == m_n[i] - 1);
         if (rst) begin
            m_run[i]   = 0;
            m_pv[i]    = 0;
            m_n[i]     = DEF;
            m_start[i] = cyc + 1;
         end else begin
            if (m_pv[i] && (sync_req || ending || !m_run[i])) begin
               m_n[i]  = m_pd[i];
               m_pv[i] = 0;
            end
            if (xfer && inr && int'(bus.cfg_ch) == i) begin
               m_pv[i] = 1;
               m_pd[i] = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
            end
            if (!m_run[i] || !ch_en[i] || sync_req || ending)
               m_start[i] = cyc + 1;
            m_run[i] = ch_en[i];
         end
      end
      m_err = !rst && xfer && !inr;
      if (rst) m_ok = 1;
      cyc++;
   end

   always @(negedge clk) begin : cmp
      logic [NCH-1:0] et, es, en;
      int pos;
      if (m_ok) begin
         for (int i = 0; i < NCH; i++) begin
            pos   = cyc - m_start[i];
            et[i] = m_run[i] && (pos == m_n[i] - 1);
            es[i] = m_run[i] && (pos < (m_n[i] + 1) / 2);
            en[i] = m_run[i] && !es[i];
         end
         chk("m_tick", 16'(tick), 16'(et));
         chk("m_sq", 16'(sq), 16'(es));
         chk("m_sq_n", 16'(sq_n), 16'(en));
         chk("m_ready", 16'(bus.cfg_ready), 16'(m_ready()));
         chk("m_err", 16'(bus.cfg_err), 16'(m_err));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // caller sits just after a rising edge; returns just after the transfer edge
   task automatic cfg_write(input int ch, input int dv);
      int k;
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 2'(ch);
      bus.cfg_div   = 8'(dv);
      k = 0;
      @(negedge clk);
      while (!bus.cfg_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) chk("cfg_timeout", 16'(k), 16'(0));
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic cap(input int ch, input int n, output logic [15:0] sv,
                      output logic [15:0] tv, output logic [15:0] nv,
                      output logic [15:0] rv);
      sv = '0; tv = '0; nv = '0; rv = '0;
      repeat (n) begin
         @(negedge clk);
         sv = {sv[14:0], sq[ch]};
         tv = {tv[14:0], tick[ch]};
         nv = {nv[14:0], sq_n[ch]};
         rv = {rv[14:0], bus.cfg_ready};
      end
   endtask

   logic [15:0] s, t, nn, r;

   initial begin
      rst = 1'b1; ch_en = '0; sync_req = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
      step(3);
      @(negedge clk);
      chk("rst_out", {sq, tick, sq_n}, 16'h0);
      chk("rst_ready", 16'(bus.cfg_ready), 16'h1);
      step(1);
      rst = 1'b0;
      ch_en[0] = 1'b1;
      cap(0, 7, s, t, nn, r);
      chk("def_sq", s, 16'b0101010);
      chk("def_tick", t, 16'b0010101);
      chk("def_sq_n", nn, 16'b0010101);

      step(1);
      cfg_write(1, 5);
      @(negedge clk);
      chk("odd_rdy_lo", 16'(bus.cfg_ready), 16'h0);
      @(negedge clk);
      chk("odd_rdy_hi", 16'(bus.cfg_ready), 16'h1);
      step(1);
      ch_en[1] = 1'b1;
      cap(1, 11, s, t, nn, r);
      chk("odd_sq", s, 16'b01110011100);
      chk("odd_tick", t, 16'b00000100001);

      step(1);
      cfg_write(2, 4);
      step(2);
      ch_en[2] = 1'b1;
      step(2);
      cfg_write(2, 7);
      cap(2, 12, s, t, nn, r);
      chk("mid_sq", s, 16'b001111000111);
      chk("mid_tick", t, 16'b010000001000);
      chk("mid_ready", r, 16'b001111111111);

      step(1);
      ch_en[1] = 1'b0;
      step(2);
      cfg_write(1, 0);
      step(2);
      ch_en[1] = 1'b1;
      cap(1, 5, s, t, nn, r);
      chk("clamp_sq", s, 16'b01010);
      chk("clamp_tick", t, 16'b00101);
      step(1);
      cfg_write(3, 9);
      @(negedge clk);
      chk("err_pulse", 16'(bus.cfg_err), 16'h1);
      @(negedge clk);
      chk("err_clear", 16'(bus.cfg_err), 16'h0);
      chk("err_ready", 16'(bus.cfg_ready), 16'h1);

      step(1);
      cfg_write(0, 3);
      cfg_write(1, 4);
      cfg_write(2, 6);
      step(20);
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      @(negedge clk);
      chk("sync_sq", 16'(sq), 16'b111);
      chk("sync_tick", 16'(tick), 16'b000);
      step(1);
      step(1);
      sync_req = 1'b1;
      @(negedge clk);
      chk("wrap_tick", 16'(tick), 16'b001);
      step(1);
      sync_req = 1'b0;
      @(negedge clk);
      chk("wsync_sq", 16'(sq), 16'b111);
      chk("wsync_tick", 16'(tick), 16'b000);

      step(1);
      cfg_write(2, 9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_out", {sq, tick, sq_n}, 16'h0);
      chk("mrst_ready", 16'(bus.cfg_ready), 16'h1);
      cap(2, 4, s, t, nn, r);
      chk("mrst_sq", s, 16'b1010);
      chk("mrst_tick", t, 16'b0101);
      step(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable divider, the parametrised successor of the fixed divide-by-2 cascade. It generates one tick strobe and one square-wave enable per channel, each with its own runtime-programmable divide ratio, all in the single `clk` domain with no derived clocks. Divisor updates are glitch-free: a new ratio is applied at the channel's next wrap. A global sync realigns all channel phases. The block feeds peripheral timing, such as baud, PWM and sampling enables.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `DIV_W`, 8: divisor width; ratio range 2..2^DIV_W-1.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ch_en`  in  CHANNELS  per-channel run request.
- `cfg_valid`  in  1  divisor write request.
- `cfg_ready`  out  1  write can be accepted this cycle.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  target channel.
- `cfg_div`  in  DIV_W  new divide ratio.
- `cfg_err`  out  1  one-cycle pulse: write addressed a nonexistent channel.
- `sync_req`  in  1  restart all running channels at phase 0.
- `tick`  out  CHANNELS  one-cycle strobe, once per period.
- `sq`  out  CHANNELS  square-wave enable at `clk`/N.
- `sq_n`  out  CHANNELS  complement of `sq` while running, 0 while stopped.

## Operation
- **Per-channel state:** `run`, `cnt[DIV_W]`, `div[DIV_W]`, `pend_v`, `pend_div[DIV_W]`.
- **Run register:** `run[i] <= ch_en[i]` every cycle.
  - While `run=0`: `cnt` is held at 0, and `tick`, `sq` and `sq_n` are all 0.
- **Counting:** while running, `cnt` counts 0..`div`-1 and then wraps to 0.
  - `tick[i] = run & (cnt == div-1)`.
  - `sq[i] = run & (cnt < ceil(div/2))`. Even N gives 50% duty; odd N is high one extra cycle.
  - All outputs are pure decode of registered state, with no combinational path from any input to `tick`, `sq` or `sq_n`.
- **Clamp:** written values below 2 are clamped to 2.
- **Config handshake:**
  - `cfg_ready = !pend_v[cfg_ch]`, or 1 when `cfg_ch` is out of range.
  - A transfer occurs when `cfg_valid & cfg_ready`.
  - In range: `pend_div <= clamp(cfg_div)`, `pend_v <= 1`.
  - Out of range: the write is dropped and `cfg_err` pulses the next cycle.
- **Applying a pending divisor:**
  - While running, it is applied on the wrap cycle (`cnt == div-1`): `div <= pend_div`, `cnt <= 0`, `pend_v <= 0`.
  - While stopped, it is applied on the cycle after acceptance.
  - A period is never truncated or stretched by a write.
- **sync_req:** on the next edge, every channel sets `cnt <= 0` and applies any pending divisor.
  - It has priority over a wrap in the same cycle; no extra `tick` is issued for the truncated period.
- **Reset:** `run=0`, `cnt=0`, `div=DEFAULT_DIV`, `pend_v=0`, `cfg_err=0`.
  - Consequently `tick=0`, `sq=0`, `sq_n=0`, and `cfg_ready=1`.
  - A reset mid-period discards pending writes.

## Timing
- **Enable latency:** `ch_en` rises at edge t → `run=1`, `sq=1` after edge t+1.
  - The first `tick` comes N-1 cycles later; subsequent ticks every N cycles.
- **Disable:** `ch_en` falls → all outputs for that channel are 0 after the next edge, and `cnt` returns to 0.
- **Config acceptance:** `cfg_ready` falls the cycle after acceptance.
  - While running, it rises the cycle after the applying wrap.
- **Back-to-back writes:** writes to different channels may occur on consecutive cycles.
- **cfg_err:** exactly one cycle, one cycle after the offending transfer.
- **sync_req:** all channels with `run=1` show `cnt=0` (`sq=1`) one cycle after `sync_req`, and so are mutually aligned.

## Structure
- **Package `clk_div_pkg`:**
  - `DIV_MIN = 2`.
  - Function `div_clamp(value)`.
  - Function `half_up(div)` returning `ceil(div/2)`.
- **Sub-module `clk_div_chan`:** holds one channel's `run`, `cnt`, `div` and pending slot plus output decode.
  - The top instantiates it CHANNELS times via generate.
  - The top also holds the cfg decode, `cfg_ready` mux, `cfg_err` register and `sync_req` fan-out.

## Test plan
- **Reset defaults:** reset, then enable channel 0 with the default → `tick` every 2 cycles, `sq` = 1,0,1,0 from the cycle after `ch_en`, `sq_n` its inverse.
- **Odd divisor:** write `cfg_div`=5 to channel 1 while stopped, then enable → `sq` high 3 cycles, low 2 cycles, `tick` on the 5th cycle of each period.
- **Mid-period write:** channel 2 running at N=4, write 7 at `cnt`=1 → the current period completes in 4 cycles, later periods are 7, and `cfg_ready` for channel 2 is low until the wrap.
- **Clamp and error:** write `cfg_div`=0 → behaves as N=2; with CHANNELS=3, write `cfg_ch`=3 → accepted, `cfg_err` pulses once, no channel changes.
- **Sync:** channels at N=3, 4 and 6 running out of phase, assert `sync_req` → all have `sq=1`, `cnt=0` on the same cycle.
  - With `sync_req` coinciding with a wrap, no extra `tick` appears.
- **Reset mid-operation:** assert `rst` with pending writes and running channels → the next cycle shows all outputs 0, `cfg_ready=1`, and `div` back to `DEFAULT_DIV`.
